centroid_frame_ctrl: RTL and testbench

//  Frame-level sequencer after the black-pixel coordinate accumulator.

---
 rtl/centroid_pkg.sv | 21 ++
 rtl/seq_divider.sv | 69 ++++++
 rtl/centroid_frame_ctrl.sv | 166 ++++++++++++++++
 tb/tb_centroid_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/centroid_pkg.sv
// Shared types and default sizes for the centroid frame sequencer.
//   state_t         : frame sequencer states
//   *_DEF           : default parameter values used by the top level
package centroid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SOF,
        ACCUM,
        SNAP,
        DIV_X,
        DIV_Y,
        PUBLISH
    } state_t;

    localparam int COORD_W_DEF     = 12;
    localparam int SUM_W_DEF       = 32;
    localparam int MIN_COUNT_DEF   = 64;
    localparam int LOST_FRAMES_DEF = 4;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, W cycles per result.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : load operands and begin (ignored while busy)
//   dividend, divisor   : operands, sampled on the start edge
//   quotient            : result, valid from the done pulse until next start
//   done                : one-cycle pulse when the quotient is final
//   busy                : division in progress
module seq_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done,
    output logic         busy
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     div_q;
    logic [W-1:0]     rem;
    logic [CNT_W-1:0] cnt;
    logic [W:0]       shifted;
    logic [W-1:0]     trial;
    logic             fits;

    // The quotient register doubles as the dividend shifter: its MSB feeds
    // the partial remainder while quotient bits enter at the LSB.
    assign shifted = {rem, quotient[W-1]};
    assign fits    = shifted >= {1'b0, div_q};
    // When fits, the difference is below the divisor, so W bits suffice.
    assign trial   = shifted[W-1:0] - div_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            quotient <= '0;
            div_q    <= '0;
            rem      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                quotient <= dividend;
                div_q    <= divisor;
                rem      <= '0;
                cnt      <= CNT_W'(W);
                busy     <= 1'b1;
            end else if (busy) begin
                if (fits) begin
                    rem      <= trial;
                    quotient <= {quotient[W-2:0], 1'b1};
                end else begin
                    rem      <= shifted[W-1:0];
                    quotient <= {quotient[W-2:0], 1'b0};
                end
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/centroid_frame_ctrl.sv
// Frame-level sequencer: snapshots x/y sums and black-pixel count at frame
// end, divides them into a centroid with one shared divider, publishes the
// result over valid/ready and flags target loss after repeated sparse frames.
//   hdmi_clk1x_i, rst_n_i      : pixel clock, synchronous active-low reset
//   enable_i                   : 1 = process frames, 0 = park in IDLE
//   lcd_vs                     : frame sync, high during the active frame
//   x_sum_i, y_sum_i, count_i  : accumulator outputs for the current frame
//   tgt_valid_o/tgt_ready_i    : centroid handshake
//   tgt_x_o, tgt_y_o           : centroid, saturated to COORD_W bits
//   tgt_lost_o                 : LOST_FRAMES consecutive sparse frames seen
//   busy_o                     : any state other than IDLE/WAIT_SOF
module centroid_frame_ctrl
    import centroid_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEF,
    parameter int SUM_W       = SUM_W_DEF,
    parameter int MIN_COUNT   = MIN_COUNT_DEF,
    parameter int LOST_FRAMES = LOST_FRAMES_DEF
) (
    input  logic               hdmi_clk1x_i,
    input  logic               rst_n_i,
    input  logic               enable_i,
    input  logic               lcd_vs,
    input  logic [SUM_W-1:0]   x_sum_i,
    input  logic [SUM_W-1:0]   y_sum_i,
    input  logic [SUM_W-1:0]   count_i,
    output logic               tgt_valid_o,
    input  logic               tgt_ready_i,
    output logic [COORD_W-1:0] tgt_x_o,
    output logic [COORD_W-1:0] tgt_y_o,
    output logic               tgt_lost_o,
    output logic               busy_o
);
    localparam int MISS_W = $clog2(LOST_FRAMES + 1);

    // A zero count must never reach the divider.
    if (MIN_COUNT < 1) begin : g_bad_min_count
        $error("MIN_COUNT must be at least 1");
    end
    if (LOST_FRAMES < 1) begin : g_bad_lost_frames
        $error("LOST_FRAMES must be at least 1");
    end
    if (SUM_W <= COORD_W) begin : g_bad_widths
        $error("SUM_W must exceed COORD_W");
    end

    state_t             state;
    logic               vs_d;
    logic [SUM_W-1:0]   x_snap, y_snap, cnt_snap;
    logic [COORD_W-1:0] qx;
    logic [MISS_W-1:0]  miss_cnt;

    logic               eof, sof, cnt_ok;
    logic               div_start, div_done, div_busy;
    logic [SUM_W-1:0]   div_dividend, div_quot;

    function automatic logic [COORD_W-1:0] sat_coord(input logic [SUM_W-1:0] q);
        return (|q[SUM_W-1:COORD_W]) ? '1 : q[COORD_W-1:0];
    endfunction

    // vs_d resets high so a low lcd_vs at reset release is not seen as EOF.
    assign eof    = vs_d & ~lcd_vs;
    assign sof    = ~vs_d & lcd_vs;
    assign cnt_ok = cnt_snap >= SUM_W'(MIN_COUNT);

    // x is divided from SNAP, y is chained on the x done pulse.
    assign div_start    = !div_busy &&
                          ((state == SNAP && cnt_ok) || (state == DIV_X && div_done));
    assign div_dividend = (state == SNAP) ? x_snap : y_snap;

    seq_divider #(.W(SUM_W)) u_div (
        .clk      (hdmi_clk1x_i),
        .rst_n    (rst_n_i),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (cnt_snap),
        .quotient (div_quot),
        .done     (div_done),
        .busy     (div_busy)
    );

    always_ff @(posedge hdmi_clk1x_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            vs_d        <= 1'b1;
            x_snap      <= '0;
            y_snap      <= '0;
            cnt_snap    <= '0;
            qx          <= '0;
            miss_cnt    <= '0;
            tgt_valid_o <= 1'b0;
            tgt_x_o     <= '0;
            tgt_y_o     <= '0;
            tgt_lost_o  <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            vs_d <= lcd_vs;
            case (state)
                IDLE: begin
                    if (enable_i) state <= WAIT_SOF;
                end
                WAIT_SOF: begin
                    if (!enable_i) begin
                        state <= IDLE;
                    end else if (sof) begin
                        state  <= ACCUM;
                        busy_o <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (!enable_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (eof) begin
                        // Accumulator still holds this frame on the EOF edge.
                        x_snap   <= x_sum_i;
                        y_snap   <= y_sum_i;
                        cnt_snap <= count_i;
                        state    <= SNAP;
                    end
                end
                SNAP: begin
                    if (cnt_ok) begin
                        miss_cnt   <= '0;
                        tgt_lost_o <= 1'b0;
                        state      <= DIV_X;
                    end else begin
                        if (miss_cnt < MISS_W'(LOST_FRAMES))
                            miss_cnt <= miss_cnt + MISS_W'(1);
                        if (miss_cnt >= MISS_W'(LOST_FRAMES - 1))
                            tgt_lost_o <= 1'b1;
                        state  <= WAIT_SOF;
                        busy_o <= 1'b0;
                    end
                end
                DIV_X: begin
                    if (div_done) begin
                        qx    <= sat_coord(div_quot);
                        state <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (div_done) begin
                        tgt_x_o     <= qx;
                        tgt_y_o     <= sat_coord(div_quot);
                        tgt_valid_o <= 1'b1;
                        state       <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    // Valid is only withdrawn by a handshake.
                    if (tgt_ready_i) begin
                        tgt_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= enable_i ? WAIT_SOF : IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_centroid_frame_ctrl.sv
// Directed bench for centroid_frame_ctrl with a behavioural model checked
// every cycle plus hand-computed literal expectations.
module tb_centroid_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, en, vs, ready;
    logic [31:0] xs, ys, cnt;
    logic        tgt_valid, tgt_lost, busy;
    logic [11:0] tgt_x, tgt_y;

    always #5 clk = ~clk;

    centroid_frame_ctrl dut (
        .hdmi_clk1x_i (clk),
        .rst_n_i      (rst_n),
        .enable_i     (en),
        .lcd_vs       (vs),
        .x_sum_i      (xs),
        .y_sum_i      (ys),
        .count_i      (cnt),
        .tgt_valid_o  (tgt_valid),
        .tgt_ready_i  (ready),
        .tgt_x_o      (tgt_x),
        .tgt_y_o      (tgt_y),
        .tgt_lost_o   (tgt_lost),
        .busy_o       (busy)
    );

    // ---------------- behavioural model ----------------
    // Modes: idle, waiting for a frame, inside a frame, deciding on the
    // snapshot, computing (fixed 66-cycle latency), publishing.
    localparam int M_IDLE = 0, M_WAIT = 1, M_FRAME = 2, M_SNAP = 3, M_CALC = 4, M_PUB = 5;

    int     m_mode, m_cd, m_miss, m_x, m_y;
    bit     m_vsd, m_valid, m_lost;
    longint snap_x, snap_y, snap_c;
    wire    m_eof = m_vsd & ~vs;
    wire    m_sof = ~m_vsd & vs;
    wire    m_busy = (m_mode == M_FRAME) || (m_mode == M_SNAP) ||
                     (m_mode == M_CALC) || (m_mode == M_PUB);

    function automatic int sat12(input longint q);
        return (q > 4095) ? 4095 : int'(q);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_cd <= 0; m_miss <= 0; m_x <= 0; m_y <= 0;
            m_vsd <= 1'b1; m_valid <= 1'b0; m_lost <= 1'b0;
        end else begin
            m_vsd <= vs;
            case (m_mode)
                M_IDLE:  if (en) m_mode <= M_WAIT;
                M_WAIT:  if (!en) m_mode <= M_IDLE; else if (m_sof) m_mode <= M_FRAME;
                M_FRAME: if (!en) m_mode <= M_IDLE;
                         else if (m_eof) begin
                             snap_x <= longint'(xs); snap_y <= longint'(ys); snap_c <= longint'(cnt);
                             m_mode <= M_SNAP;
                         end
                M_SNAP: begin
                    if (snap_c < 64) begin
                        m_miss <= (m_miss < 4) ? m_miss + 1 : 4;
                        if (m_miss >= 3) m_lost <= 1'b1;
                        m_mode <= M_WAIT;
                    end else begin
                        m_miss <= 0; m_lost <= 1'b0; m_cd <= 66; m_mode <= M_CALC;
                    end
                end
                M_CALC: begin
                    m_cd <= m_cd - 1;
                    if (m_cd == 1) begin
                        m_x <= sat12(snap_x / snap_c);
                        m_y <= sat12(snap_y / snap_c);
                        m_valid <= 1'b1;
                        m_mode <= M_PUB;
                    end
                end
                M_PUB: if (ready) begin
                    m_valid <= 1'b0;
                    m_mode <= en ? M_WAIT : M_IDLE;
                end
                default: m_mode <= M_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    int cyc_total = 0, cyc_bad = 0;
    bit chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            cyc_total++;
            if (tgt_valid !== m_valid || tgt_lost !== m_lost || busy !== m_busy ||
                int'(tgt_x) != m_x || int'(tgt_y) != m_y) begin
                cyc_bad++;
                $display("FAIL model_cycle t=%0t got v=%0b x=%0d y=%0d lost=%0b busy=%0b want v=%0b x=%0d y=%0d lost=%0b busy=%0b",
                         $time, tgt_valid, tgt_x, tgt_y, tgt_lost, busy,
                         m_valid, m_x, m_y, m_lost, m_busy);
            end
        end
    end

    // ---------------- literal checks and stimulus ----------------
    int lit_total = 0, lit_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        lit_total++;
        if (act != exp) begin
            lit_bad++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tgt_valid && n < 300);
        chk("valid_within_300", longint'(tgt_valid), 1);
    endtask

    task automatic frame_begin(input logic [31:0] fx, fy, fc, input int act);
        @(negedge clk); vs = 1'b1; xs = fx; ys = fy; cnt = fc;
        repeat (act - 1) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk); vs = 1'b0;
    endtask

    // Sums stay put on the EOF edge and clear one cycle later.
    task automatic frame(input logic [31:0] fx, fy, fc, input int act, input int blank);
        frame_begin(fx, fy, fc, act);
        frame_end();
        @(negedge clk); xs = '0; ys = '0; cnt = '0;
        repeat (blank - 1) @(negedge clk);
    endtask

    int n;

    initial begin
        rst_n = 1'b0; en = 1'b1; vs = 1'b0; ready = 1'b1;
        xs = '0; ys = '0; cnt = '0;
        @(posedge clk);
        @(negedge clk); chk_on = 1'b1;
        @(negedge clk);
        chk("reset_valid", tgt_valid, 0);
        chk("reset_x", tgt_x, 0);
        chk("reset_busy", busy, 0);

        // Release with lcd_vs low: no false frame end.
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rel_low_vs_valid", tgt_valid, 0);
        chk("rel_low_vs_busy", busy, 0);

        // Basic centroid, latency and single-cycle pulse.
        frame_begin(32'd6400, 32'd3200, 32'd64, 5);
        frame_end();
        wait_valid(n);
        chk("t1_latency", n - 1, 67);
        chk("t1_x", tgt_x, 100);
        chk("t1_y", tgt_y, 50);
        @(negedge clk);
        chk("t1_pulse", tgt_valid, 0);
        repeat (3) @(negedge clk);

        // Sparse frames raise lost on the fourth; a good frame clears it.
        for (int i = 0; i < 4; i++) begin
            frame(32'd0, 32'd0, 32'd63, 5, 3);
            chk("t2_lost", tgt_lost, (i == 3) ? 1 : 0);
            chk("t2_valid", tgt_valid, 0);
        end
        frame(32'd1000, 32'd2000, 32'd100, 5, 3);
        chk("t2_lost_clear", tgt_lost, 0);
        wait_valid(n);
        chk("t2_x", tgt_x, 10);
        chk("t2_y", tgt_y, 20);
        repeat (3) @(negedge clk);

        // Back-pressure holds data and drops later frames.
        ready = 1'b0;
        frame(32'd3000, 32'd1500, 32'd100, 5, 3);
        wait_valid(n);
        for (int i = 0; i < 3; i++) frame(32'd5000, 32'd5000, 32'd100, 5, 3);
        chk("t3_hold_valid", tgt_valid, 1);
        chk("t3_hold_x", tgt_x, 30);
        chk("t3_hold_y", tgt_y, 15);
        ready = 1'b1;
        @(negedge clk);
        chk("t3_release", tgt_valid, 0);
        frame(32'd7000, 32'd700, 32'd100, 5, 3);
        wait_valid(n);
        chk("t3_next_x", tgt_x, 70);
        chk("t3_next_y", tgt_y, 7);
        repeat (3) @(negedge clk);

        // Saturation, then reset while dividing y.
        frame(32'hFFFF_FFFF, 32'd640, 32'd64, 5, 3);
        wait_valid(n);
        chk("t4_sat_x", tgt_x, 4095);
        chk("t4_y", tgt_y, 10);
        repeat (3) @(negedge clk);
        frame_begin(32'd320, 32'd448, 32'd64, 5);
        frame_end();
        repeat (45) @(negedge clk);
        chk("t4_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_rst_valid", tgt_valid, 0);
        chk("t4_rst_x", tgt_x, 0);
        chk("t4_rst_y", tgt_y, 0);
        chk("t4_rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4_no_resume", busy, 0);

        // Disable mid-frame, then re-enable mid-frame.
        frame_begin(32'd640, 32'd640, 32'd64, 3);
        en = 1'b0;
        @(negedge clk);
        chk("t5_idle_busy", busy, 0);
        repeat (2) @(negedge clk);
        frame_end();
        @(negedge clk); xs = '0; ys = '0; cnt = '0;
        repeat (3) @(negedge clk);
        chk("t5_eof_ignored", busy, 0);
        frame_begin(32'd640, 32'd640, 32'd64, 2);
        en = 1'b1;
        repeat (3) @(negedge clk);
        frame_end();
        @(negedge clk); xs = '0; ys = '0; cnt = '0;
        repeat (2) @(negedge clk);
        chk("t5_skipped", busy, 0);
        frame(32'd1280, 32'd1920, 32'd64, 5, 3);
        wait_valid(n);
        chk("t5_x", tgt_x, 20);
        chk("t5_y", tgt_y, 30);
        repeat (5) @(negedge clk);

        chk_on = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", cyc_total + lit_total, cyc_bad + lit_bad);
        $finish;
    end

endmodule
